lsu_io_buffer: RTL and testbench
================================

Name: lsu_io_buffer

Overview:
- Load-return and memory-mapped I/O stage directly downstream of the LSU address/byte-enable decoder.
- Holds the output-buffer peripheral registers: LEDR, LEDG, HEX3-0, HEX7-4 and LCD.
- Synchronises and debounces the switch input buffer.
- Selects, aligns and sign-extends load data from DMEM or the I/O buffers, returning it to writeback with a fixed 1-cycle latency.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable synchronised samples required before the switch register updates (minimum 1).
- SW_WIDTH, 17, number of implemented switch bits; upper bits read 0.

Ports:
- i_clk  in  1  system clock; all state on rising edge.
- i_reset  in  1  asynchronous active-low reset.
- i_lsu_addr  in  32  load/store byte address.
- i_funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- i_lsu_wren  in  1  store request.
- i_lsu_rden  in  1  load request.
- i_sel_lsu  in  2  target select: 00 DMEM, 01 input buffer, 10 output buffer, 11 unmapped.
- i_byte_en  in  4  per-lane write enable, lane-aligned.
- i_wdata_out_buff  in  32  lane-aligned store data.
- i_dmem_rdata  in  32  DMEM word read data, valid one cycle after the request.
- i_io_sw  in  32  raw asynchronous switch pins.
- o_ld_data  out  32  aligned, extended load result.
- o_ld_valid  out  1  load result valid pulse.
- o_misaligned  out  1  pulse alongside o_ld_valid for misaligned loads.
- o_io_ledr  out  32  LEDR register; bits 31:17 are 0.
- o_io_ledg  out  32  LEDG register; bits 31:8 are 0.
- o_io_hex0 .. o_io_hex7  out  7 each  seven-segment registers.
- o_io_lcd  out  32  LCD control register.

Behaviour:
- Reset (i_reset=0, asynchronous):
  - all peripheral registers, switch sync/debounce state, debounce counter and the pipeline registers clear to 0;
  - o_ld_valid, o_misaligned and o_ld_data read 0 immediately;
  - a load in flight when reset asserts is dropped (no valid pulse after reset releases).
- Output-buffer register select: i_lsu_addr[14:12]
  - 0 = LEDR, 1 = LEDG, 2 = HEX3-0 (byte n holds hex n), 3 = HEX7-4, 4 = LCD;
  - 5-7 ignore writes and read 0.
- Stores:
  - A write occurs when i_lsu_wren=1 and i_sel_lsu=10.
  - Each lane k with i_byte_en[k]=1 loads i_wdata_out_buff[8k+7:8k] into the selected register at the clock edge.
  - Unimplemented bits stay 0: LEDR[31:17], LEDG[31:8], bit 7 of each HEX byte.
  - A write to sel 01 (switch input buffer, read-only) is ignored.
- Loads, stage 0:
  - When i_lsu_rden=1, the block captures i_sel_lsu, i_lsu_addr[14:12], i_lsu_addr[1:0] and i_funct3 into pipeline registers.
  - For sel 01/10 it also captures the raw selected register word.
- Loads, stage 1 (next cycle):
  - o_ld_valid=1 for exactly one cycle.
  - Source word: i_dmem_rdata for sel 00, the captured word for sel 01/10, 0 for sel 11.
  - Byte/halfword is extracted at offset addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word through.
- Back-to-back loads: one result per cycle, no bubbles.
- Store vs load ordering: a store in cycle N is visible to a load issued in cycle N+1.
- i_lsu_wren and i_lsu_rden both high in one cycle: the store is performed, the load is discarded, and no o_ld_valid follows.
- Misalignment:
  - halfword with addr[0]=1, or word with addr[1:0]≠00;
  - o_ld_valid=1, o_misaligned=1, o_ld_data=0.
- Illegal funct3 (011, 110, 111) on a load: treated as LW.
- Switch path:
  - i_io_sw[SW_WIDTH-1:0] passes through a 2-flop synchroniser.
  - A candidate register and a counter track stability: when the synchronised value differs from the candidate, candidate takes the new value and the counter resets to 0.
  - When the counter reaches DEBOUNCE_CYCLES-1 the value is committed to the switch register; the counter saturates there.
  - The switch register reads on any sel 01 load regardless of address bits.

Test Plan:
- Reset, then store 0x0001_ABCD to LEDR with byte_en=1111 -> after the edge, o_io_ledr=0x0001_ABCD; store 0xFFFF_FFFF -> 0x0001_FFFF (bits 31:17 masked).
- Store 0x8281_0000 to HEX3-0 with byte_en=1100 -> o_io_hex3=0x02, o_io_hex2=0x01, hex1/hex0 unchanged; LW of the same address next cycle -> o_ld_data=0x0201_xxxx, o_ld_valid one cycle after the request.
- DMEM load with i_dmem_rdata=0x80FF_7F01: LB at offset 3 -> 0xFFFF_FF80; LBU at offset 3 -> 0x0000_0080; LH at offset 2 -> 0xFFFF_80FF; LH at offset 1 -> o_misaligned=1, data 0.
- i_io_sw glitches 0x1 for 2 cycles then returns to 0, with DEBOUNCE_CYCLES=4 -> switch register stays 0; held at 0x15 -> a sel 01 LW reads 0x15 exactly 2+4 cycles after the change.
- Loads issued on 3 consecutive cycles -> 3 consecutive o_ld_valid pulses with matching data; i_reset asserted mid-stream -> all outputs 0 at once and no further valid pulses.
- i_lsu_wren and i_lsu_rden asserted together on LEDG with data 0xA5 -> o_io_ledg=0xA5 and no o_ld_valid the following cycle.

Source files
------------

// File: rtl/lsu_io_buffer.sv
// Memory-mapped I/O and load-return stage behind the LSU decoder: output-buffer
// peripheral registers, debounced switch input, and 1-cycle aligned load return.
module lsu_io_buffer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SW_WIDTH        = 17
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_lsu_addr,
  input  logic [2:0]  i_funct3,
  input  logic        i_lsu_wren,
  input  logic        i_lsu_rden,
  input  logic [1:0]  i_sel_lsu,
  input  logic [3:0]  i_byte_en,
  input  logic [31:0] i_wdata_out_buff,
  input  logic [31:0] i_dmem_rdata,
  input  logic [31:0] i_io_sw,
  output logic [31:0] o_ld_data,
  output logic        o_ld_valid,
  output logic        o_misaligned,
  output logic [31:0] o_io_ledr,
  output logic [31:0] o_io_ledg,
  output logic [6:0]  o_io_hex0,
  output logic [6:0]  o_io_hex1,
  output logic [6:0]  o_io_hex2,
  output logic [6:0]  o_io_hex3,
  output logic [6:0]  o_io_hex4,
  output logic [6:0]  o_io_hex5,
  output logic [6:0]  o_io_hex6,
  output logic [6:0]  o_io_hex7,
  output logic [31:0] o_io_lcd
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [16:0]      ledr_q, ledr_d;
  logic [7:0]       ledg_q, ledg_d;
  logic [7:0][6:0]  hex_q, hex_d;
  logic [31:0]      lcd_q, lcd_d;

  logic [SW_WIDTH-1:0] sw_meta_q, sw_sync_q;
  logic [SW_WIDTH-1:0] sw_cand_q, sw_cand_d;
  logic [SW_WIDTH-1:0] sw_reg_q, sw_reg_d;
  logic [CNT_W-1:0]    deb_cnt_q, deb_cnt_d;

  logic        ld_pend_q, ld_pend_d;
  logic [1:0]  ld_sel_q, ld_sel_d;
  logic [1:0]  ld_off_q, ld_off_d;
  logic [2:0]  ld_funct3_q, ld_funct3_d;
  logic [31:0] ld_word_q, ld_word_d;

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  be);
    logic [31:0] r;
    r = old_w;
    for (int k = 0; k < 4; k++) begin
      if (be[k]) r[8*k +: 8] = wdata[8*k +: 8];
    end
    return r;
  endfunction

  logic [31:0] ledr_w, ledg_w, hexlo_w, hexhi_w, sw_w;
  logic [31:0] ledr_m, ledg_m, hexlo_m, hexhi_m, lcd_m;

  assign ledr_w  = {15'b0, ledr_q};
  assign ledg_w  = {24'b0, ledg_q};
  assign hexlo_w = {1'b0, hex_q[3], 1'b0, hex_q[2], 1'b0, hex_q[1], 1'b0, hex_q[0]};
  assign hexhi_w = {1'b0, hex_q[7], 1'b0, hex_q[6], 1'b0, hex_q[5], 1'b0, hex_q[4]};
  assign sw_w    = 32'(sw_reg_q);

  assign ledr_m  = merge_lanes(ledr_w,  i_wdata_out_buff, i_byte_en);
  assign ledg_m  = merge_lanes(ledg_w,  i_wdata_out_buff, i_byte_en);
  assign hexlo_m = merge_lanes(hexlo_w, i_wdata_out_buff, i_byte_en);
  assign hexhi_m = merge_lanes(hexhi_w, i_wdata_out_buff, i_byte_en);
  assign lcd_m   = merge_lanes(lcd_q,   i_wdata_out_buff, i_byte_en);

  // Unimplemented bits of each register are simply never stored.
  always_comb begin
    ledr_d = ledr_q;
    ledg_d = ledg_q;
    hex_d  = hex_q;
    lcd_d  = lcd_q;
    if (i_lsu_wren && (i_sel_lsu == 2'b10)) begin
      case (i_lsu_addr[14:12])
        3'd0: ledr_d = ledr_m[16:0];
        3'd1: ledg_d = ledg_m[7:0];
        3'd2: begin
          hex_d[0] = hexlo_m[6:0];
          hex_d[1] = hexlo_m[14:8];
          hex_d[2] = hexlo_m[22:16];
          hex_d[3] = hexlo_m[30:24];
        end
        3'd3: begin
          hex_d[4] = hexhi_m[6:0];
          hex_d[5] = hexhi_m[14:8];
          hex_d[6] = hexhi_m[22:16];
          hex_d[7] = hexhi_m[30:24];
        end
        3'd4: lcd_d = lcd_m;
        default: ;
      endcase
    end
  end

  // Candidate restarts on every change; commit once it has been stable long enough.
  always_comb begin
    sw_cand_d = sw_cand_q;
    deb_cnt_d = deb_cnt_q;
    sw_reg_d  = sw_reg_q;
    if (sw_sync_q != sw_cand_q) begin
      sw_cand_d = sw_sync_q;
      deb_cnt_d = '0;
    end else if (deb_cnt_q != CNT_MAX) begin
      deb_cnt_d = deb_cnt_q + CNT_W'(1);
    end
    if (deb_cnt_d == CNT_MAX) sw_reg_d = sw_cand_d;
  end

  logic [31:0] rd_word;
  always_comb begin
    rd_word = '0;
    case (i_sel_lsu)
      2'b01: rd_word = sw_w;
      2'b10: begin
        case (i_lsu_addr[14:12])
          3'd0:    rd_word = ledr_w;
          3'd1:    rd_word = ledg_w;
          3'd2:    rd_word = hexlo_w;
          3'd3:    rd_word = hexhi_w;
          3'd4:    rd_word = lcd_q;
          default: rd_word = '0;
        endcase
      end
      default: rd_word = '0;
    endcase
  end

  // A load issued together with a store is dropped; the store wins.
  always_comb begin
    ld_pend_d   = i_lsu_rden && !i_lsu_wren;
    ld_sel_d    = ld_sel_q;
    ld_off_d    = ld_off_q;
    ld_funct3_d = ld_funct3_q;
    ld_word_d   = ld_word_q;
    if (ld_pend_d) begin
      ld_sel_d    = i_sel_lsu;
      ld_off_d    = i_lsu_addr[1:0];
      ld_funct3_d = i_funct3;
      ld_word_d   = rd_word;
    end
  end

  logic [2:0]  f3_eff;
  logic [31:0] src_word, shifted, ext_data;
  logic        mis;

  always_comb begin
    case (ld_funct3_q)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_eff = ld_funct3_q;
      default:                                f3_eff = 3'b010;
    endcase
    case (ld_sel_q)
      2'b00:        src_word = i_dmem_rdata;
      2'b01, 2'b10: src_word = ld_word_q;
      default:      src_word = '0;
    endcase
    shifted = src_word >> {ld_off_q, 3'b000};
    case (f3_eff)
      3'b000:  ext_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  ext_data = {24'b0, shifted[7:0]};
      3'b001:  ext_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  ext_data = {16'b0, shifted[15:0]};
      default: ext_data = src_word;
    endcase
    mis = (((f3_eff == 3'b001) || (f3_eff == 3'b101)) && ld_off_q[0]) ||
          ((f3_eff == 3'b010) && (ld_off_q != 2'b00));
  end

  assign o_ld_valid   = ld_pend_q;
  assign o_misaligned = ld_pend_q && mis;
  assign o_ld_data    = (ld_pend_q && !mis) ? ext_data : '0;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      ledr_q      <= '0;
      ledg_q      <= '0;
      hex_q       <= '0;
      lcd_q       <= '0;
      sw_meta_q   <= '0;
      sw_sync_q   <= '0;
      sw_cand_q   <= '0;
      sw_reg_q    <= '0;
      deb_cnt_q   <= '0;
      ld_pend_q   <= 1'b0;
      ld_sel_q    <= '0;
      ld_off_q    <= '0;
      ld_funct3_q <= '0;
      ld_word_q   <= '0;
    end else begin
      ledr_q      <= ledr_d;
      ledg_q      <= ledg_d;
      hex_q       <= hex_d;
      lcd_q       <= lcd_d;
      sw_meta_q   <= i_io_sw[SW_WIDTH-1:0];
      sw_sync_q   <= sw_meta_q;
      sw_cand_q   <= sw_cand_d;
      sw_reg_q    <= sw_reg_d;
      deb_cnt_q   <= deb_cnt_d;
      ld_pend_q   <= ld_pend_d;
      ld_sel_q    <= ld_sel_d;
      ld_off_q    <= ld_off_d;
      ld_funct3_q <= ld_funct3_d;
      ld_word_q   <= ld_word_d;
    end
  end

  assign o_io_ledr = ledr_w;
  assign o_io_ledg = ledg_w;
  assign o_io_hex0 = hex_q[0];
  assign o_io_hex1 = hex_q[1];
  assign o_io_hex2 = hex_q[2];
  assign o_io_hex3 = hex_q[3];
  assign o_io_hex4 = hex_q[4];
  assign o_io_hex5 = hex_q[5];
  assign o_io_hex6 = hex_q[6];
  assign o_io_hex7 = hex_q[7];
  assign o_io_lcd  = lcd_q;

  logic unused_bits;
  assign unused_bits = ^{i_lsu_addr[31:15], i_lsu_addr[11:2], ledr_m[31:17], ledg_m[31:8],
                         hexlo_m[31], hexlo_m[23], hexlo_m[15], hexlo_m[7],
                         hexhi_m[31], hexhi_m[23], hexhi_m[15], hexhi_m[7]};

  if (SW_WIDTH < 32) begin : g_sw_unused
    logic unused_sw;
    assign unused_sw = ^i_io_sw[31:SW_WIDTH];
  end

endmodule

// File: tb/tb_lsu_io_buffer.sv
// Self-checking bench for lsu_io_buffer: peripheral stores, aligned loads,
// switch debounce, back-to-back loads, reset behaviour and store/load collision.
module tb_lsu_io_buffer;
  localparam int DEB = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] lsu_addr = '0;
  logic [2:0]  funct3 = '0;
  logic        lsu_wren = 1'b0;
  logic        lsu_rden = 1'b0;
  logic [1:0]  sel_lsu = '0;
  logic [3:0]  byte_en = '0;
  logic [31:0] wdata = '0;
  logic [31:0] dmem_rdata = '0;
  logic [31:0] io_sw = '0;
  logic [31:0] ld_data, io_ledr, io_ledg, io_lcd;
  logic        ld_valid, misaligned;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;

  lsu_io_buffer #(.DEBOUNCE_CYCLES(DEB), .SW_WIDTH(17)) dut (
    .i_clk(clk), .i_reset(rst_n), .i_lsu_addr(lsu_addr), .i_funct3(funct3),
    .i_lsu_wren(lsu_wren), .i_lsu_rden(lsu_rden), .i_sel_lsu(sel_lsu),
    .i_byte_en(byte_en), .i_wdata_out_buff(wdata), .i_dmem_rdata(dmem_rdata),
    .i_io_sw(io_sw), .o_ld_data(ld_data), .o_ld_valid(ld_valid),
    .o_misaligned(misaligned), .o_io_ledr(io_ledr), .o_io_ledg(io_ledg),
    .o_io_hex0(hex0), .o_io_hex1(hex1), .o_io_hex2(hex2), .o_io_hex3(hex3),
    .o_io_hex4(hex4), .o_io_hex5(hex5), .o_io_hex6(hex6), .o_io_hex7(hex7),
    .o_io_lcd(io_lcd)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DMEM model: word returned one cycle after the read request
  logic [31:0] mem [16];
  always @(posedge clk) if (lsu_rden) dmem_rdata <= mem[lsu_addr[5:2]];

  // bench-side register model
  logic [31:0] m_ledr = '0, m_ledg = '0, m_hexlo = '0, m_hexhi = '0, m_lcd = '0;

  int n_cmp = 0;
  int n_fail = 0;

  // scoreboard: {misaligned, data}, due cycle
  logic [32:0] exp_q[$];
  int          due_q[$];

  always @(negedge clk) begin
    logic [32:0] e;
    if (exp_q.size() > 0 && due_q[0] == cyc) begin
      e = exp_q.pop_front();
      void'(due_q.pop_front());
      n_cmp++;
      if (!ld_valid || {misaligned, ld_data} !== e) begin
        n_fail++;
        $display("FAIL load_result: got valid=%0b mis=%0b data=%h, want valid=1 mis=%0b data=%h",
                 ld_valid, misaligned, ld_data, e[32], e[31:0]);
      end
    end else if (ld_valid) begin
      n_cmp++;
      n_fail++;
      $display("FAIL unexpected_valid: got valid=1 data=%h, want no valid", ld_data);
    end
  end

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  function automatic logic [31:0] model_read(input logic [2:0] rsel);
    case (rsel)
      3'd0: return m_ledr;
      3'd1: return m_ledg;
      3'd2: return m_hexlo;
      3'd3: return m_hexhi;
      3'd4: return m_lcd;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [32:0] expect_load(input logic [31:0] w, input logic [1:0] off,
                                              input logic [2:0] f3);
    logic [2:0]  f;
    logic [7:0]  b;
    logic [15:0] h;
    f = (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) ? 3'b010 : f3;
    case (off)
      2'd0: b = w[7:0];
      2'd1: b = w[15:8];
      2'd2: b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (f)
      3'b000: return {1'b0, {24{b[7]}}, b};
      3'b100: return {1'b0, 24'h0, b};
      3'b001: return off[0] ? {1'b1, 32'h0} : {1'b0, {16{h[15]}}, h};
      3'b101: return off[0] ? {1'b1, 32'h0} : {1'b0, 16'h0, h};
      default: return (off != 2'd0) ? {1'b1, 32'h0} : {1'b0, w};
    endcase
  endfunction

  function automatic logic [31:0] mk_addr(input logic [2:0] rsel, input logic [1:0] off);
    logic [31:0] a;
    a = $urandom;
    a[14:12] = rsel;
    a[1:0] = off;
    return a;
  endfunction

  // driver tasks: called at posedge+1, return at the next posedge+1
  task automatic do_store(input logic [1:0] sel, input logic [2:0] rsel,
                          input logic [31:0] data, input logic [3:0] be);
    logic [31:0] m;
    m = lane_mask(be);
    lsu_addr = mk_addr(rsel, 2'd0);
    sel_lsu = sel; wdata = data; byte_en = be; lsu_wren = 1'b1;
    @(posedge clk); #1;
    lsu_wren = 1'b0;
    if (sel == 2'b10) begin
      case (rsel)
        3'd0: m_ledr  = ((m_ledr & ~m) | (data & m)) & 32'h0001_FFFF;
        3'd1: m_ledg  = ((m_ledg & ~m) | (data & m)) & 32'h0000_00FF;
        3'd2: m_hexlo = ((m_hexlo & ~m) | (data & m)) & 32'h7F7F_7F7F;
        3'd3: m_hexhi = ((m_hexhi & ~m) | (data & m)) & 32'h7F7F_7F7F;
        3'd4: m_lcd   = (m_lcd & ~m) | (data & m);
        default: ;
      endcase
    end
  endtask

  task automatic do_load(input logic [1:0] sel, input logic [31:0] addr,
                         input logic [2:0] f3, input logic [31:0] word);
    lsu_addr = addr; sel_lsu = sel; funct3 = f3; lsu_rden = 1'b1;
    exp_q.push_back(expect_load(word, addr[1:0], f3));
    due_q.push_back(cyc + 1);
    @(posedge clk); #1;
    lsu_rden = 1'b0;
  endtask

  task automatic load_buf(input logic [2:0] rsel, input logic [1:0] off, input logic [2:0] f3);
    do_load(2'b10, mk_addr(rsel, off), f3, model_read(rsel));
  endtask

  task automatic load_dmem(input logic [3:0] idx, input logic [1:0] off, input logic [2:0] f3);
    logic [31:0] a;
    a = ($urandom & 32'hFFFF_FFC0) | {26'h0, idx, off};
    do_load(2'b00, a, f3, mem[idx]);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    n_cmp++;
    if ({ld_valid, misaligned, ld_data} !== 34'h0) begin
      n_fail++;
      $display("FAIL reset_load_out: got %b/%b/%h, want 0/0/0", ld_valid, misaligned, ld_data);
    end
    n_cmp++;
    if ({io_ledr, io_ledg, io_lcd, hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0} !== '0) begin
      n_fail++;
      $display("FAIL reset_periph: got ledr=%h ledg=%h lcd=%h, want all 0", io_ledr, io_ledg, io_lcd);
    end
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_ledr_store();
    do_store(2'b10, 3'd0, 32'h0001_ABCD, 4'b1111);
    n_cmp++;
    if (io_ledr !== 32'h0001_ABCD) begin
      n_fail++; $display("FAIL ledr_store: got %h, want 0001abcd", io_ledr);
    end
    do_store(2'b10, 3'd0, 32'hFFFF_FFFF, 4'b1111);
    n_cmp++;
    if (io_ledr !== 32'h0001_FFFF) begin
      n_fail++; $display("FAIL ledr_mask: got %h, want 0001ffff", io_ledr);
    end
    load_buf(3'd0, 2'd0, 3'b010);
    load_buf(3'd0, 2'd2, 3'b101);
  endtask

  task automatic test_hex();
    do_store(2'b10, 3'd2, 32'h0C0B_0A09, 4'b0011);
    do_store(2'b10, 3'd2, 32'h8281_0000, 4'b1100);
    n_cmp++;
    if ({hex3, hex2, hex1, hex0} !== {7'h02, 7'h01, 7'h0A, 7'h09}) begin
      n_fail++;
      $display("FAIL hex_store: got %h %h %h %h, want 02 01 0a 09", hex3, hex2, hex1, hex0);
    end
    load_buf(3'd2, 2'd0, 3'b010);
    do_store(2'b10, 3'd3, 32'hFFEE_DDCC, 4'b0101);
    n_cmp++;
    if ({hex7, hex6, hex5, hex4} !== {7'h00, 7'h6E, 7'h00, 7'h4C}) begin
      n_fail++;
      $display("FAIL hex_hi_store: got %h %h %h %h, want 00 6e 00 4c", hex7, hex6, hex5, hex4);
    end
    load_buf(3'd3, 2'd2, 3'b000);
    load_buf(3'd2, 2'd3, 3'b000);
  endtask

  task automatic test_dmem_loads();
    mem[0] = 32'h80FF_7F01;
    load_dmem(4'd0, 2'd3, 3'b000);
    load_dmem(4'd0, 2'd3, 3'b100);
    load_dmem(4'd0, 2'd2, 3'b001);
    load_dmem(4'd0, 2'd1, 3'b001);
    load_dmem(4'd0, 2'd0, 3'b010);
    load_dmem(4'd0, 2'd2, 3'b010);
    load_dmem(4'd0, 2'd0, 3'b011);
    load_dmem(4'd0, 2'd1, 3'b110);
    load_dmem(4'd0, 2'd1, 3'b000);
    for (int i = 0; i < 12; i++) begin
      logic [2:0] f;
      f = 3'($urandom_range(0, 7));
      load_dmem(4'($urandom_range(1, 15)), 2'($urandom_range(0, 3)), f);
    end
  endtask

  task automatic test_debounce();
    io_sw = 32'h1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    io_sw = 32'h0;
    repeat (10) @(posedge clk);
    #1;
    do_load(2'b01, mk_addr(3'd5, 2'd0), 3'b010, 32'h0);
    repeat (4) @(posedge clk);
    #1;
    io_sw = 32'hABC0_0015;
    for (int j = 0; j < 9; j++) begin
      do_load(2'b01, mk_addr(3'($urandom_range(0, 7)), 2'd0), 3'b010,
              (j >= 2 + DEB) ? 32'h15 : 32'h0);
    end
    do_load(2'b01, mk_addr(3'd6, 2'd0), 3'b100, 32'h15);
  endtask

  task automatic test_back_to_back();
    mem[7] = 32'h1234_8765;
    load_buf(3'd0, 2'd1, 3'b100);
    load_dmem(4'd7, 2'd2, 3'b001);
    load_buf(3'd2, 2'd0, 3'b010);
    load_dmem(4'd7, 2'd0, 3'b001);
  endtask

  task automatic test_misc();
    do_store(2'b10, 3'd4, 32'hDEAD_BEEF, 4'b1001);
    n_cmp++;
    if (io_lcd !== 32'hDE00_00EF) begin
      n_fail++; $display("FAIL lcd_store: got %h, want de0000ef", io_lcd);
    end
    do_store(2'b10, 3'd5, 32'h1111_1111, 4'b1111);
    do_store(2'b01, 3'd0, 32'h0000_0000, 4'b1111);
    n_cmp++;
    if (io_ledr !== m_ledr || io_lcd !== m_lcd) begin
      n_fail++; $display("FAIL ignored_store: got ledr=%h lcd=%h, want %h %h", io_ledr, io_lcd, m_ledr, m_lcd);
    end
    load_buf(3'd5, 2'd0, 3'b010);
    load_buf(3'd4, 2'd0, 3'b111);
    do_load(2'b11, mk_addr(3'd0, 2'd0), 3'b010, 32'h0);
    do_load(2'b11, mk_addr(3'd0, 2'd2), 3'b010, 32'h0);
  endtask

  task automatic test_wr_rd_collision();
    lsu_addr = mk_addr(3'd1, 2'd0);
    sel_lsu = 2'b10; wdata = 32'h0000_00A5; byte_en = 4'b0001; funct3 = 3'b010;
    lsu_wren = 1'b1; lsu_rden = 1'b1;
    @(posedge clk); #1;
    lsu_wren = 1'b0; lsu_rden = 1'b0;
    m_ledg = 32'hA5;
    @(negedge clk);
    n_cmp++;
    if (ld_valid !== 1'b0) begin
      n_fail++; $display("FAIL collision_valid: got %b, want 0", ld_valid);
    end
    n_cmp++;
    if (io_ledg !== 32'h0000_00A5) begin
      n_fail++; $display("FAIL collision_ledg: got %h, want 000000a5", io_ledg);
    end
    @(posedge clk); #1;
    load_buf(3'd1, 2'd0, 3'b010);
  endtask

  task automatic test_reset_midstream();
    load_buf(3'd0, 2'd0, 3'b010);
    load_buf(3'd2, 2'd0, 3'b010);
    lsu_addr = mk_addr(3'd0, 2'd0); sel_lsu = 2'b10; funct3 = 3'b010; lsu_rden = 1'b1;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    due_q.delete();
    m_ledr = '0; m_ledg = '0; m_hexlo = '0; m_hexhi = '0; m_lcd = '0;
    n_cmp++;
    if ({ld_valid, misaligned, ld_data} !== 34'h0) begin
      n_fail++;
      $display("FAIL midreset_load_out: got %b/%b/%h, want 0/0/0", ld_valid, misaligned, ld_data);
    end
    n_cmp++;
    if ({io_ledr, io_ledg, io_lcd, hex3, hex2, hex1, hex0} !== '0) begin
      n_fail++; $display("FAIL midreset_periph: got ledr=%h ledg=%h, want 0 0", io_ledr, io_ledg);
    end
    lsu_rden = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if (ld_valid !== 1'b0) begin
        n_fail++; $display("FAIL post_reset_valid: got %b, want 0", ld_valid);
      end
    end
    @(posedge clk); #1;
    load_buf(3'd0, 2'd0, 3'b010);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    test_reset();
    test_ledr_store();
    test_hex();
    test_dmem_loads();
    test_debounce();
    test_back_to_back();
    test_misc();
    test_wr_rd_collision();
    test_reset_midstream();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL missing_results: got %0d outstanding, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
